// File: rtl/router_fifo.sv
// 16 x 9 packet FIFO between the router register stage and one destination client.
// Tag bit 8 marks header bytes; a packet byte counter blanks data_out once the packet has drained.
module router_fifo (
    input  logic       clock,
    input  logic       rst,
    input  logic       soft_reset,
    input  logic       write_enb,
    input  logic       read_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty
);

    logic [8:0] mem_q [16];
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [5:0] count_q, count_d;
    logic [7:0] data_out_q, data_out_d;
    logic       clear;
    logic       wr_acc;
    logic       rd_acc;
    logic [8:0] rd_entry;

    assign full     = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) && (wr_ptr_q[4] != rd_ptr_q[4]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign clear    = rst || soft_reset;
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[3:0]];
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 5'd1;
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + 5'd1;
                data_out_d = rd_entry[7:0];
                // Header length field covers payload only; +1 accounts for the parity byte.
                if (rd_entry[8]) begin
                    count_d = rd_entry[7:2] + 6'd1;
                end else if (count_q != 6'd0) begin
                    count_d = count_q - 6'd1;
                end
            end else if (count_q == 6'd0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is never cleared; pointer reset alone makes old entries unreachable.
    always_ff @(posedge clock) begin
        if (!clear && wr_acc) begin
            mem_q[wr_ptr_q[3:0]] <= {lfd_state, data_in};
        end
    end

endmodule
